// File: rtl/tb_exit_mon_pkg.sv
// Shared types and default addresses for the testbench exit monitor.
package tb_exit_mon_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_e;

  localparam logic [63:0] TOHOST_ADDR_DEF  = 64'h1100_0000;
  localparam logic [63:0] CONSOLE_ADDR_DEF = 64'h1100_4000;
  localparam int unsigned EXIT_CODE_W      = 31;

endpackage

// File: rtl/tb_exit_mon_fifo.sv
// First-word-fall-through byte FIFO with sticky overflow; a full push without a
// simultaneous pop is dropped.
module tb_exit_mon_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];
  logic          empty, full, do_pop, do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_i && !do_push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign valid_o    = ~empty;
  assign data_o     = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_o = ovf_q;

endmodule

// File: rtl/tb_exit_monitor.sv
// Passive snoop of the bridge-to-SRAM bus: tohost verdict, cycle counter and
// console FIFO. EXIT_MON_WATCHDOG_EN enables the cycle-count watchdog.
module tb_exit_monitor
  import tb_exit_mon_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 64,
  parameter int unsigned           DATA_WIDTH     = 64,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = ADDR_WIDTH'(TOHOST_ADDR_DEF),
  parameter logic [ADDR_WIDTH-1:0] CONSOLE_ADDR   = ADDR_WIDTH'(CONSOLE_ADDR_DEF),
  parameter int unsigned           FIFO_DEPTH     = 8,
  parameter int unsigned           CNT_WIDTH      = 32,
  parameter int unsigned           TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    done_o,
  output logic                    pass_o,
  output logic                    timeout_o,
  output logic [EXIT_CODE_W-1:0]  exit_code_o,
  output logic [CNT_WIDTH-1:0]    cycle_count_o,
  output logic                    char_valid_o,
  output logic [7:0]              char_o,
  input  logic                    char_ready_i,
  output logic                    char_overflow_o
);

`ifdef EXIT_MON_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  mon_state_e             state_q, state_d;
  logic [EXIT_CODE_W-1:0] code_q, code_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic                   wr, tohost_wr, console_wr, wd_fire;
  logic                   unused_bits;

  // Word-granular address decode; the byte offset within the word is ignored.
  assign wr         = req_i & we_i;
  assign tohost_wr  = wr && (addr_i[ADDR_WIDTH-1:3] == TOHOST_ADDR[ADDR_WIDTH-1:3]) &&
                      (be_i[3:0] == 4'hF) && wdata_i[0];
  assign console_wr = wr && (addr_i[ADDR_WIDTH-1:3] == CONSOLE_ADDR[ADDR_WIDTH-1:3]) &&
                      be_i[0];
  assign wd_fire    = WD_EN && (cnt_q == WD_LAST);

  assign unused_bits = ^{addr_i[2:0], be_i[DATA_WIDTH/8-1:4], wdata_i[DATA_WIDTH-1:32]};

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    if (state_q == RUN) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
      // A tohost write in the same cycle takes priority over the watchdog.
      if (tohost_wr) begin
        state_d = (wdata_i[EXIT_CODE_W:1] == '0) ? PASS : FAIL;
        code_d  = wdata_i[EXIT_CODE_W:1];
      end else if (wd_fire) begin
        state_d = TIMEOUT;
        code_d  = '1;
      end
    end
    done_d = (state_d != RUN);
    pass_d = (state_d == PASS);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      code_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

`ifdef EXIT_MON_WATCHDOG_EN
  logic timeout_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) timeout_q <= 1'b0;
    else         timeout_q <= (state_d == TIMEOUT);
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign exit_code_o   = code_q;
  assign cycle_count_o = cnt_q;

  tb_exit_mon_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (console_wr),
    .data_i     (wdata_i[7:0]),
    .pop_i      (char_ready_i),
    .data_o     (char_o),
    .valid_o    (char_valid_o),
    .overflow_o (char_overflow_o)
  );

endmodule

// File: doc/tb_exit_monitor.md
Name: tb_exit_monitor

Overview:
- Passive snoop stage directly downstream of the AXI-to-memory bridge; taps the same req/we/addr/be/wdata bus that feeds the testbench SRAM, in parallel with it.
- Never drives or stalls that bus.
- Decodes writes to a tohost word to produce the end-of-test verdict and exit code, runs a cycle counter with a watchdog, and buffers console byte writes in a small FIFO for the bench to drain.

Parameters:
- ADDR_WIDTH, 64, snooped address width.
- DATA_WIDTH, 64, snooped data width; fixed at 64.
- TOHOST_ADDR, 64'h1100_0000, byte address of the tohost word; must be 8-byte aligned.
- CONSOLE_ADDR, 64'h1100_4000, byte address of the console register; must be 8-byte aligned.
- FIFO_DEPTH, 8, console FIFO entries; must be a power of 2 and at least 2.
- CNT_WIDTH, 32, cycle counter width.
- TIMEOUT_CYCLES, 1000000, watchdog limit; only used when EXIT_MON_WATCHDOG_EN is defined.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  memory request strobe.
- we_i  in  1  write enable.
- addr_i  in  ADDR_WIDTH  byte address.
- be_i  in  DATA_WIDTH/8  byte enables.
- wdata_i  in  DATA_WIDTH  write data.
- done_o  out  1  test finished; sticky.
- pass_o  out  1  valid when done_o=1.
- timeout_o  out  1  watchdog fired; sticky.
- exit_code_o  out  31  captured exit code.
- cycle_count_o  out  CNT_WIDTH  cycles spent in RUN.
- char_valid_o  out  1  console FIFO not empty.
- char_o  out  8  FIFO head byte.
- char_ready_i  in  1  bench pops the head byte.
- char_overflow_o  out  1  sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-low.
  - State = RUN.
  - done_o, pass_o, timeout_o, char_valid_o, char_overflow_o = 0.
  - exit_code_o = 0, cycle_count_o = 0, char_o = 0.
  - FIFO empty.
- Write detection, evaluated each cycle as wr = req_i & we_i.
  - Word match compares addr_i[ADDR_WIDTH-1:3] with the parameter address [ADDR_WIDTH-1:3]; addr_i[2:0] are ignored.
- Tohost write: wr & word match on TOHOST_ADDR & be_i[3:0]==4'hF & wdata_i[0]==1.
  - Writes with wdata_i[0]==0 or a partial be_i[3:0] are ignored.
- States: RUN, PASS, FAIL, TIMEOUT. All non-RUN states are terminal until reset.
  - RUN -> PASS on a tohost write with wdata_i[31:1]==0.
  - RUN -> FAIL on a tohost write with wdata_i[31:1]!=0.
  - On either transition, exit_code_o <= wdata_i[31:1].
- Outputs are registered: done_o and pass_o assert on the clock edge after the write cycle (1-cycle latency).
  - pass_o=1 only in PASS.
  - done_o=1 in PASS, FAIL and TIMEOUT.
- cycle_count_o increments every cycle in RUN, saturates at all-ones, and freezes once the state leaves RUN.
- In terminal states, further tohost writes are ignored. Console writes are still accepted.
- Console write: wr & word match on CONSOLE_ADDR & be_i[0].
  - Pushes wdata_i[7:0]; other lanes are ignored.
- FIFO:
  - First-word-fall-through; char_o shows the head byte when char_valid_o=1.
  - Pop when char_valid_o & char_ready_i.
  - Push when full and no pop in the same cycle: byte dropped, char_overflow_o set.
  - Push and pop in the same cycle when full: both succeed; count unchanged.
  - Push and pop in the same cycle when empty: the push is visible next cycle; the pop is a no-op.
  - Pointers are log2(FIFO_DEPTH)+1 bits with wrap; full/empty are derived from the MSB compare.
- A write matching neither address has no effect.
- The block has no outputs toward the memory bus.
- Reset mid-test: all state returns to reset values at once; FIFO contents are lost.

Optional Feature:
- Macro: EXIT_MON_WATCHDOG_EN.
- Defined:
  - In RUN, when cycle_count_o == TIMEOUT_CYCLES-1 and there is no tohost write that cycle, next state = TIMEOUT.
  - TIMEOUT sets timeout_o=1, done_o=1, pass_o=0, exit_code_o = all ones.
  - A tohost write in the same cycle wins over the watchdog.
- Not defined:
  - No TIMEOUT state; timeout_o is tied to 0; TIMEOUT_CYCLES is unused.
  - The counter still runs and saturates.

Decomposition:
- Package tb_exit_mon_pkg holds:
  - mon_state_e enum {RUN, PASS, FAIL, TIMEOUT}.
  - Default TOHOST_ADDR and CONSOLE_ADDR constants.
  - The exit-code width constant (31).
- One sub-module: tb_exit_mon_fifo, a parameterised 8-bit FWFT FIFO with push/pop/full/empty and overflow handling.

Test Plan:
- Tohost write, addr 0x1100_0000, be 0xFF, wdata 0x1 at cycle 50 -> next cycle done_o=1, pass_o=1, exit_code_o=0, cycle_count_o frozen at 51.
- Tohost write, wdata 0x0000_0A73 -> FAIL, exit_code_o=0x539, pass_o=0. A later write of 0x1 does not change the verdict.
- Tohost write with be 0x0E, then with wdata 0x2 -> both ignored; state stays RUN.
- FIFO_DEPTH=8, char_ready_i=0:
  - 9 console writes of 'A'..'I' -> char_overflow_o=1; 8 bytes held.
  - Then raise char_ready_i -> char_o emits 'A'..'H' in order; 'I' is not emitted.
  - A simultaneous push and pop while full keeps count 8.
- With EXIT_MON_WATCHDOG_EN and TIMEOUT_CYCLES=100, no tohost write -> at cycle 100 timeout_o=1, done_o=1, exit_code_o=0x7FFF_FFFF. Without the macro: no timeout.
- Assert rst_ni low mid-stream after FAIL with 3 bytes queued -> asynchronously all outputs return to 0; FIFO empty.
